// File: rtl/fft_sample_loader_if.sv
// ============================================================================
// Module  : fft_sample_loader_if
// Brief   : ROM fetch bus and frame hand-off bus between loader and FFT side.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface fft_sample_loader_if #(
    parameter int N_POINTS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 16
);
    logic                           rom_rd;
    logic [ADDR_W-1:0]              rom_addr;
    logic [2*DATA_W-1:0]            rom_data;
    logic [N_POINTS*2*DATA_W-1:0]   frame_data;
    logic                           frame_valid;
    logic                           frame_ready;

    modport master (
        output rom_rd,
        output rom_addr,
        input  rom_data,
        output frame_data,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  rom_rd,
        input  rom_addr,
        output rom_data,
        input  frame_data,
        input  frame_valid,
        output frame_ready
    );
endinterface

`default_nettype wire

// File: rtl/fft_sample_loader.sv
// ============================================================================
// Module  : fft_sample_loader
// Brief   : Fetches one ROM sample per slow_clk rise, packs a frame, hands it off.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fft_sample_loader #(
    parameter int N_POINTS    = 32,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock_in,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 slow_clk,
    fft_sample_loader_if.master  bus,
    output logic [7:0]           frame_count,
    output logic                 overrun
);

    localparam int SAMPLE_W = 2 * DATA_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TICK = 3'd1,
        ST_READ      = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_FULL      = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic                     prev_q, prev_d;
    logic [ADDR_W-1:0]        idx_q, idx_d;
    logic                     rom_rd_q, rom_rd_d;
    logic [ADDR_W-1:0]        rom_addr_q, rom_addr_d;
    logic [SAMPLE_W-1:0]      slot_q [N_POINTS];
    logic [SAMPLE_W-1:0]      slot_d [N_POINTS];
    logic                     frame_valid_q, frame_valid_d;
    logic [7:0]               frame_count_q, frame_count_d;
    logic                     overrun_q, overrun_d;
    logic                     tick;

    // slow_clk is asynchronous: resynchronise, then detect its rising edge
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], slow_clk};
        prev_d = sync_q[SYNC_STAGES-1];
        tick   = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        rom_rd_d      = 1'b0;
        rom_addr_d    = rom_addr_q;
        slot_d        = slot_q;
        frame_valid_d = frame_valid_q;
        frame_count_d = frame_count_q;
        overrun_d     = overrun_q;

        case (state_q)
            ST_IDLE: begin
                frame_valid_d = 1'b0;
                if (enable) begin
                    state_d   = ST_WAIT_TICK;
                    idx_d     = '0;
                    overrun_d = 1'b0;
                end
            end

            ST_WAIT_TICK: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (tick) begin
                    rom_rd_d   = 1'b1;
                    rom_addr_d = idx_q;
                    state_d    = ST_READ;
                end
            end

            ST_READ: begin
                if (tick) begin
                    overrun_d = 1'b1;
                end
                state_d = ST_CAPTURE;
            end

            // ROM data is valid during this cycle, one cycle after the strobe
            ST_CAPTURE: begin
                if (tick) begin
                    overrun_d = 1'b1;
                end
                slot_d[idx_q] = bus.rom_data;
                if (idx_q == LAST_IDX) begin
                    idx_d         = '0;
                    frame_valid_d = 1'b1;
                    state_d       = ST_FULL;
                end else if (enable) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_WAIT_TICK;
                end else begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            // A pending frame is always delivered, even if enable drops
            ST_FULL: begin
                if (tick) begin
                    overrun_d = 1'b1;
                end
                if (frame_valid_q && bus.frame_ready) begin
                    frame_count_d = frame_count_q + 8'd1;
                    frame_valid_d = 1'b0;
                    state_d       = enable ? ST_WAIT_TICK : ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sync_q        <= '0;
            prev_q        <= 1'b0;
            idx_q         <= '0;
            rom_rd_q      <= 1'b0;
            rom_addr_q    <= '0;
            frame_valid_q <= 1'b0;
            frame_count_q <= 8'd0;
            overrun_q     <= 1'b0;
            for (int k = 0; k < N_POINTS; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            prev_q        <= prev_d;
            idx_q         <= idx_d;
            rom_rd_q      <= rom_rd_d;
            rom_addr_q    <= rom_addr_d;
            frame_valid_q <= frame_valid_d;
            frame_count_q <= frame_count_d;
            overrun_q     <= overrun_d;
            slot_q        <= slot_d;
        end
    end

    always_comb begin
        for (int k = 0; k < N_POINTS; k++) begin
            bus.frame_data[k*SAMPLE_W +: SAMPLE_W] = slot_q[k];
        end
    end

    assign bus.rom_rd      = rom_rd_q;
    assign bus.rom_addr    = rom_addr_q;
    assign bus.frame_valid = frame_valid_q;
    assign frame_count     = frame_count_q;
    assign overrun         = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_sample_loader.sv
// ============================================================================
// Module  : tb_fft_sample_loader
// Brief   : Scoreboard bench for fft_sample_loader with ROM[k] = {k,-k}.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fft_sample_loader;

    localparam int N_POINTS    = 32;
    localparam int ADDR_W      = 5;
    localparam int DATA_W      = 16;
    localparam int SYNC_STAGES = 2;
    localparam int FRAME_W     = N_POINTS * 2 * DATA_W;

    logic       clock_in = 1'b0;
    logic       rst_n    = 1'b0;
    logic       enable   = 1'b0;
    logic       slow_clk = 1'b0;
    logic [7:0] frame_count;
    logic       overrun;

    int         n_vec       = 0;
    int         n_fail      = 0;
    int         frames_seen = 0;
    int         addr_q[$];
    int         frame_q[$];
    logic [7:0] exp_count     = 8'd0;
    logic       count_pending = 1'b0;
    logic       rd_prev       = 1'b0;

    fft_sample_loader_if #(.N_POINTS(N_POINTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    fft_sample_loader #(
        .N_POINTS(N_POINTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clock_in    (clock_in),
        .rst_n       (rst_n),
        .enable      (enable),
        .slow_clk    (slow_clk),
        .bus         (bus.master),
        .frame_count (frame_count),
        .overrun     (overrun)
    );

    // 10 ns system clock; 53 ns slow clock, deliberately not phase-locked
    always #5    clock_in = ~clock_in;
    always #26.5 slow_clk = ~slow_clk;

    function automatic logic [31:0] rom_word(input int k);
        logic [15:0] re;
        logic [15:0] im;
        re = 16'(k);
        im = 16'(-k);
        return {re, im};
    endfunction

    function automatic int bad_slots(input logic [FRAME_W-1:0] f);
        int n;
        n = 0;
        for (int k = 0; k < N_POINTS; k++) begin
            if (f[k*32 +: 32] !== rom_word(k)) n++;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ROM model: registered read, data one cycle after the strobe
    always @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) bus.rom_data <= '0;
        else if (bus.rom_rd) bus.rom_data <= rom_word(int'(bus.rom_addr));
    end

    // Read monitor
    always @(negedge clock_in) begin
        int e;
        if (!rst_n) begin
            rd_prev = 1'b0;
        end else begin
            if (bus.rom_rd) begin
                check("rom_rd_width", 64'(rd_prev), 64'd0);
                if (addr_q.size() == 0) begin
                    check("rom_rd_unexpected", 64'd1, 64'd0);
                end else begin
                    e = addr_q.pop_front();
                    check("rom_addr", 64'(bus.rom_addr), 64'(e));
                end
            end
            rd_prev = bus.rom_rd;
        end
    end

    // Frame monitor
    always @(negedge clock_in) begin
        if (!rst_n) begin
            exp_count     = 8'd0;
            count_pending = 1'b0;
        end else begin
            if (count_pending) begin
                check("frame_count", 64'(frame_count), 64'(exp_count));
                check("frame_valid_drop", 64'(bus.frame_valid), 64'd0);
                count_pending = 1'b0;
            end
            if (bus.frame_valid && bus.frame_ready) begin
                if (frame_q.size() == 0) begin
                    check("frame_unexpected", 64'd1, 64'd0);
                end else begin
                    void'(frame_q.pop_front());
                    check("frame_slots_bad", 64'(bad_slots(bus.frame_data)), 64'd0);
                end
                exp_count     = exp_count + 8'd1;
                frames_seen   = frames_seen + 1;
                count_pending = 1'b1;
            end
        end
    end

    task automatic push_frame(input int nsamp, input bit with_frame);
        for (int k = 0; k < nsamp; k++) addr_q.push_back(k);
        if (with_frame) frame_q.push_back(0);
    endtask

    // Returns one negedge after the hand-off edge
    task automatic wait_frames(input int target, input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clock_in);
            if (frames_seen >= target) break;
        end
        check(name, 64'(frames_seen >= target), 64'd1);
        @(negedge clock_in);
    endtask

    task automatic wait_read_of(input int addr, input int budget, input string name);
        int i;
        bit seen;
        seen = 1'b0;
        for (i = 0; i < budget; i++) begin
            @(negedge clock_in);
            if (bus.rom_rd && int'(bus.rom_addr) == addr) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 64'(seen), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rom_rd"},      64'(bus.rom_rd),      64'd0);
        check({tag, "_rom_addr"},    64'(bus.rom_addr),    64'd0);
        check({tag, "_frame_valid"}, 64'(bus.frame_valid), 64'd0);
        check({tag, "_frame_count"}, 64'(frame_count),     64'd0);
        check({tag, "_overrun"},     64'(overrun),         64'd0);
        check({tag, "_frame_data"},  64'(|bus.frame_data), 64'd0);
    endtask

    initial begin
        int lowcnt;
        int hicnt;
        bit got_valid;

        bus.frame_ready = 1'b1;
        #3;
        check_all_zero("reset");
        repeat (3) @(negedge clock_in);
        rst_n = 1'b1;

        // 1: one full frame with ready held high
        push_frame(N_POINTS, 1'b1);
        push_frame(N_POINTS, 1'b1);
        enable = 1'b1;
        wait_frames(1, 400, "t1_frame_timeout");
        bus.frame_ready = 1'b0;
        check("t1_frame_count", 64'(frame_count), 64'd1);
        check("t1_overrun", 64'(overrun), 64'd0);

        // 2: back-pressure while slow_clk keeps ticking
        got_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock_in);
            if (bus.frame_valid) begin
                got_valid = 1'b1;
                break;
            end
        end
        check("t2_valid_timeout", 64'(got_valid), 64'd1);
        lowcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock_in);
            if (!bus.frame_valid) lowcnt++;
        end
        check("t2_valid_held", 64'(lowcnt), 64'd0);
        check("t2_frame_stable_bad", 64'(bad_slots(bus.frame_data)), 64'd0);
        check("t2_overrun", 64'(overrun), 64'd1);
        check("t2_count_held", 64'(frame_count), 64'd1);
        push_frame(10, 1'b0);
        bus.frame_ready = 1'b1;
        wait_frames(2, 100, "t2_accept_timeout");

        // 3: drop enable after ten samples
        wait_read_of(9, 400, "t3_read9_timeout");
        @(negedge clock_in);
        enable = 1'b0;
        hicnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock_in);
            if (bus.frame_valid) hicnt++;
        end
        check("t3_no_frame", 64'(hicnt), 64'd0);
        check("t3_overrun_sticky", 64'(overrun), 64'd1);
        check("t3_addr_q_drained", 64'(addr_q.size()), 64'd0);
        push_frame(N_POINTS, 1'b1);
        enable = 1'b1;
        repeat (2) @(negedge clock_in);
        check("t3_overrun_cleared", 64'(overrun), 64'd0);
        wait_frames(3, 400, "t3_frame_timeout");

        // 4: asynchronous reset during the fetch of sample 17
        push_frame(18, 1'b0);
        wait_read_of(17, 400, "t4_read17_timeout");
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t4");
        check("t4_addr_q_drained", 64'(addr_q.size()), 64'd0);
        repeat (3) @(negedge clock_in);
        rst_n = 1'b1;
        push_frame(N_POINTS, 1'b1);
        wait_frames(4, 400, "t4_frame_timeout");

        // 5: 256 back-to-back frames, count wraps through zero
        for (int f = 0; f < 256; f++) push_frame(N_POINTS, 1'b1);
        wait_frames(260, 60000, "t5_frames_timeout");
        check("t5_frame_count_wrapped", 64'(frame_count), 64'(8'((1 + 256) % 256)));
        check("t5_overrun", 64'(overrun), 64'd0);
        check("t5_addr_q_drained", 64'(addr_q.size()), 64'd0);
        check("t5_frame_q_drained", 64'(frame_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
